// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Registers the MEM/WB boundary, waits for
//            data-memory read responses (with a bounded timeout), extracts and
//            sign/zero-extends load data, selects the writeback source and
//            drives the register-file write port. Owns stall_mem, which
//            freezes every upstream pipeline register while a load response
//            is outstanding.
// Ports    : clk, rst_n (sync, active-low)
//            MEM stage in : mem_valid, write_en_mem, write_reg_mem, wb_sel_mem,
//                           rd_en_mem, width_mem, unsigned_sel_mem,
//                           alu_result_mem, next_pc_mem, random_mem
//            Dmem resp in : dmem_rvalid, dmem_rdata
//            RF port out  : write_enable, write_reg, write_data
//            Status out   : stall_mem, load_fault (sticky), retired_count
// Options  : WB_RETIRE_CNT_EN - when defined, builds the 32-bit retired
//            instruction counter; otherwise retired_count is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        write_en_mem,
  input  logic [4:0]  write_reg_mem,
  input  logic [1:0]  wb_sel_mem,
  input  logic        rd_en_mem,
  input  logic [1:0]  width_mem,
  input  logic        unsigned_sel_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] next_pc_mem,
  input  logic [31:0] random_mem,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        write_enable,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        stall_mem,
  output logic        load_fault,
  output logic [31:0] retired_count
);

  localparam logic [0:0]  c_ST_RUN       = 1'b0;
  localparam logic [0:0]  c_ST_LOAD_WAIT = 1'b1;
  localparam logic [15:0] c_LOAD_TIMEOUT = 16'(LOAD_TIMEOUT);

  localparam logic [1:0]  c_SEL_ALU  = 2'd0;
  localparam logic [1:0]  c_SEL_LOAD = 2'd1;
  localparam logic [1:0]  c_SEL_LINK = 2'd2;

  localparam logic [1:0]  c_W_BYTE = 2'd0;
  localparam logic [1:0]  c_W_HALF = 2'd1;

  // MEM/WB pipeline register
  logic        r_wb_valid;
  logic        r_wb_write_en;
  logic [4:0]  r_wb_write_reg;
  logic [1:0]  r_wb_sel;
  logic        r_wb_rd_en;
  logic [1:0]  r_wb_width;
  logic        r_wb_unsigned_sel;
  logic [31:0] r_wb_alu_result;
  logic [31:0] r_wb_next_pc;
  logic [31:0] r_wb_random;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [15:0] r_count;
  logic        r_load_fault;

  logic        w_timeout_hit;
  logic        w_stall;
  logic        w_retire;
  logic [1:0]  w_offset;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_valid        <= 1'b0;
      r_wb_write_en     <= 1'b0;
      r_wb_write_reg    <= 5'd0;
      r_wb_sel          <= 2'd0;
      r_wb_rd_en        <= 1'b0;
      r_wb_width        <= 2'd0;
      r_wb_unsigned_sel <= 1'b0;
      r_wb_alu_result   <= 32'd0;
      r_wb_next_pc      <= 32'd0;
      r_wb_random       <= 32'd0;
    end else if (!w_stall) begin
      r_wb_valid        <= mem_valid;
      r_wb_write_en     <= write_en_mem;
      r_wb_write_reg    <= write_reg_mem;
      r_wb_sel          <= wb_sel_mem;
      r_wb_rd_en        <= rd_en_mem;
      r_wb_width        <= width_mem;
      r_wb_unsigned_sel <= unsigned_sel_mem;
      r_wb_alu_result   <= alu_result_mem;
      r_wb_next_pc      <= next_pc_mem;
      r_wb_random       <= random_mem;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (r_wb_valid && r_wb_rd_en && !dmem_rvalid) begin
          w_state_next = c_ST_LOAD_WAIT;
        end
      end
      default: begin
        if (dmem_rvalid || (r_count == c_LOAD_TIMEOUT)) begin
          w_state_next = c_ST_RUN;
        end
      end
    endcase
  end

  // FSM: outputs. A load stalls from its first cycle in WB, even before the
  // FSM has moved to LOAD_WAIT, so the upstream stages never overrun it.
  always_comb begin
    w_timeout_hit = (r_state == c_ST_LOAD_WAIT) && (r_count == c_LOAD_TIMEOUT)
                    && !dmem_rvalid;
    w_stall       = r_wb_valid && r_wb_rd_en && !dmem_rvalid && !w_timeout_hit;
    w_retire      = r_wb_valid && (!r_wb_rd_en || dmem_rvalid || w_timeout_hit);
  end

  // Wait counter: held at 0 in RUN, so it is already clear on LOAD_WAIT entry.
  // Saturates at the timeout value; the FSM leaves LOAD_WAIT on that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 16'd0;
    end else if (r_state == c_ST_RUN) begin
      r_count <= 16'd0;
    end else if (r_count != c_LOAD_TIMEOUT) begin
      r_count <= r_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_fault <= 1'b0;
    end else if (w_timeout_hit) begin
      r_load_fault <= 1'b1;
    end
  end

  // Load lane extraction. Half-word loads use only offset bit 1.
  always_comb begin
    w_offset = r_wb_alu_result[1:0];
    w_byte   = dmem_rdata[{w_offset, 3'b000} +: 8];
    w_half   = dmem_rdata[{w_offset[1], 4'b0000} +: 16];
    case (r_wb_width)
      c_W_BYTE: w_load_data = {{24{!r_wb_unsigned_sel && w_byte[7]}}, w_byte};
      c_W_HALF: w_load_data = {{16{!r_wb_unsigned_sel && w_half[15]}}, w_half};
      default:  w_load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (r_wb_sel)
      c_SEL_ALU:  write_data = r_wb_alu_result;
      c_SEL_LOAD: write_data = w_timeout_hit ? 32'd0 : w_load_data;
      c_SEL_LINK: write_data = r_wb_next_pc;
      default:    write_data = r_wb_random;
    endcase
  end

  assign write_enable = w_retire && r_wb_write_en && (r_wb_write_reg != 5'd0);
  assign write_reg    = r_wb_write_reg;
  assign stall_mem    = w_stall;
  assign load_fault   = r_load_fault;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retired_count;

  // Counts every retire, including faulted loads and x0 writes; wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired_count <= 32'd0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign retired_count = r_retired_count;
`else
  assign retired_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage. Expected register-file
//            writes are queued when instructions are issued and compared by a
//            monitor whenever write_enable is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  localparam int c_TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        write_en_mem;
  logic [4:0]  write_reg_mem;
  logic [1:0]  wb_sel_mem;
  logic        rd_en_mem;
  logic [1:0]  width_mem;
  logic        unsigned_sel_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] next_pc_mem;
  logic [31:0] random_mem;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        stall_mem;
  logic        load_fault;
  logic [31:0] retired_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [31:0] exp_cnt;

  writeback_stage #(.LOAD_TIMEOUT(c_TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_valid        (mem_valid),
    .write_en_mem     (write_en_mem),
    .write_reg_mem    (write_reg_mem),
    .wb_sel_mem       (wb_sel_mem),
    .rd_en_mem        (rd_en_mem),
    .width_mem        (width_mem),
    .unsigned_sel_mem (unsigned_sel_mem),
    .alu_result_mem   (alu_result_mem),
    .next_pc_mem      (next_pc_mem),
    .random_mem       (random_mem),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .write_enable     (write_enable),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .stall_mem        (stall_mem),
    .load_fault       (load_fault),
    .retired_count    (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%08h, required no write",
                 write_reg, write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (write_reg !== e.rd || write_data !== e.data) begin
          n_fail++;
          $display("FAIL write_port: got rd=%0d data=%08h, required rd=%0d data=%08h",
                   write_reg, write_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Present one instruction to MEM and let the next edge capture it.
  task automatic issue(input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                       input logic rden, input logic [1:0] width, input logic uns,
                       input logic [31:0] alu, input logic [31:0] npc,
                       input logic [31:0] rnd);
    mem_valid        = 1'b1;
    write_en_mem     = wen;
    write_reg_mem    = rd;
    wb_sel_mem       = sel;
    rd_en_mem        = rden;
    width_mem        = width;
    unsigned_sel_mem = uns;
    alu_result_mem   = alu;
    next_pc_mem      = npc;
    random_mem       = rnd;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    mem_valid     = 1'b0;
    write_en_mem  = 1'b0;
    rd_en_mem     = 1'b0;
  endtask

  task automatic check_count(input string name);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = exp_retired;
`else
    exp_cnt = 32'd0;
`endif
    n_checks++;
    if (retired_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s: retired_count=%0d, required %0d", name, retired_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bubble();
    write_reg_mem = 5'd0; wb_sel_mem = 2'd0; width_mem = 2'd0; unsigned_sel_mem = 1'b0;
    alu_result_mem = 32'd0; next_pc_mem = 32'd0; random_mem = 32'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({write_enable, write_reg, write_data, stall_mem, load_fault} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b rd=%0d data=%08h stall=%b fault=%b, required all 0",
               write_enable, write_reg, write_data, stall_mem, load_fault);
    end
    exp_retired = 32'd0;
    check_count("reset_count");
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    push(5'd5, 32'h0000_1234);
    issue(1'b1, 5'd5, 2'd0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h0000_0400, 32'h5555_AAAA);
    bubble();
    exp_retired++;
    @(negedge clk);
    n_checks++;
    if (write_enable !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h0000_1234 ||
        stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_write: we=%b rd=%0d data=%08h stall=%b, required 1/5/00001234/0",
               write_enable, write_reg, write_data, stall_mem);
    end
    @(posedge clk); #1;
    check_count("alu_count");
  endtask

  task automatic test_back_to_back();
    push(5'd1, 32'h0000_000A);
    push(5'd2, 32'h0000_0100);
    push(5'd3, 32'hDEAD_BEEF);
    issue(1'b1, 5'd1, 2'd0, 1'b0, 2'd2, 1'b0, 32'h0000_000A, 32'h0000_0111, 32'h1111_1111);
    issue(1'b1, 5'd2, 2'd2, 1'b0, 2'd2, 1'b0, 32'h0000_0222, 32'h0000_0100, 32'h2222_2222);
    issue(1'b1, 5'd3, 2'd3, 1'b0, 2'd2, 1'b0, 32'h0000_0333, 32'h0000_0333, 32'hDEAD_BEEF);
    bubble();
    exp_retired += 3;
    @(posedge clk); #1;
    check_count("b2b_count");
    // Bubble with write_en set must neither write nor count.
    mem_valid = 1'b0; write_en_mem = 1'b1; write_reg_mem = 5'd4;
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_write: we=%b, required 0", write_enable);
    end
    @(posedge clk); #1;
    check_count("bubble_count");
  endtask

  task automatic load_late(input logic uns, input logic [31:0] expd);
    push(5'd6, expd);
    issue(1'b1, 5'd6, 2'd1, 1'b1, 2'd0, uns, 32'h1000_0003, 32'h0, 32'h0);
    bubble();
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (stall_mem !== 1'b1 || write_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait_%0d: stall=%b we=%b, required 1/0", i, stall_mem, write_enable);
      end
      @(posedge clk); #1;
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_0000;
    @(negedge clk);
    n_checks++;
    if (stall_mem !== 1'b0 || write_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL load_resp: stall=%b we=%b, required 0/1", stall_mem, write_enable);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    exp_retired++;
  endtask

  task automatic test_load_byte();
    load_late(1'b0, 32'hFFFF_FF80);
    load_late(1'b1, 32'h0000_0080);
    check_count("load_byte_count");
  endtask

  task automatic load_now(input logic [1:0] width, input logic uns, input logic [1:0] off,
                          input logic [31:0] rdata, input logic [31:0] expd);
    push(5'd8, expd);
    issue(1'b1, 5'd8, 2'd1, 1'b1, width, uns, {30'h0, off}, 32'h0, 32'h0);
    bubble();
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    n_checks++;
    if (stall_mem !== 1'b0 || write_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL load_now: stall=%b we=%b, required 0/1", stall_mem, write_enable);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    exp_retired++;
  endtask

  task automatic test_load_half_word();
    load_now(2'd1, 1'b1, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF);
    load_now(2'd1, 1'b0, 2'd1, 32'h1234_8001, 32'hFFFF_8001);
    load_now(2'd2, 1'b1, 2'd0, 32'h8000_0001, 32'h8000_0001);
    load_now(2'd0, 1'b0, 2'd1, 32'h0000_7F00, 32'h0000_007F);
    check_count("load_hw_count");
  endtask

  task automatic test_x0();
    issue(1'b1, 5'd0, 2'd0, 1'b0, 2'd2, 1'b0, 32'hCAFE_0000, 32'h0, 32'h0);
    bubble();
    exp_retired++;
    @(negedge clk);
    n_checks++;
    if (write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write: we=%b, required 0", write_enable);
    end
    @(posedge clk); #1;
    check_count("x0_count");
  endtask

  // A younger ALU op waiting in MEM must be held until the load retires.
  task automatic test_load_hold_next();
    push(5'd10, 32'h0000_00AB);
    push(5'd11, 32'h0000_5678);
    issue(1'b1, 5'd10, 2'd1, 1'b1, 2'd0, 1'b1, 32'h0000_0000, 32'h0, 32'h0);
    issue(1'b1, 5'd11, 2'd0, 1'b0, 2'd2, 1'b0, 32'h0000_5678, 32'h0, 32'h0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_00AB;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    bubble();
    @(negedge clk);
    n_checks++;
    if (write_enable !== 1'b1 || write_reg !== 5'd11) begin
      n_fail++;
      $display("FAIL held_next: we=%b rd=%0d, required 1/11", write_enable, write_reg);
    end
    @(posedge clk); #1;
    exp_retired += 2;
    check_count("hold_count");
  endtask

  task automatic test_timeout();
    push(5'd7, 32'h0000_0000);
    issue(1'b1, 5'd7, 2'd1, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 32'h0);
    bubble();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'hFFFF_FFFF;
    for (int i = 0; i <= c_TIMEOUT; i++) begin
      @(negedge clk);
      n_checks++;
      if (stall_mem !== 1'b1 || load_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait_%0d: stall=%b fault=%b, required 1/0", i, stall_mem, load_fault);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (stall_mem !== 1'b0 || write_enable !== 1'b1 || write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_retire: stall=%b we=%b data=%08h, required 0/1/00000000",
               stall_mem, write_enable, write_data);
    end
    @(posedge clk); #1;
    exp_retired++;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (load_fault !== 1'b1 || write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL late_resp: fault=%b we=%b, required 1/0", load_fault, write_enable);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (load_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: fault=%b, required 1", load_fault);
    end
    check_count("timeout_count");
  endtask

  task automatic test_reset_in_wait();
    issue(1'b1, 5'd9, 2'd1, 1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h0);
    bubble();
    dmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_retired = 32'd0;
    @(negedge clk);
    n_checks++;
    if ({write_enable, write_reg, write_data, stall_mem, load_fault} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_wait: we=%b rd=%0d data=%08h stall=%b fault=%b, required all 0",
               write_enable, write_reg, write_data, stall_mem, load_fault);
    end
    check_count("reset_wait_count");
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (write_enable !== 1'b0 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL discarded_load: we=%b stall=%b, required 0/0", write_enable, stall_mem);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    // Pipeline still works after the reset.
    push(5'd12, 32'h0000_0042);
    issue(1'b1, 5'd12, 2'd0, 1'b0, 2'd2, 1'b0, 32'h0000_0042, 32'h0, 32'h0);
    bubble();
    exp_retired++;
    repeat (2) @(posedge clk);
    #1;
    check_count("post_reset_count");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_byte();
    test_load_half_word();
    test_x0();
    test_load_hold_next();
    test_timeout();
    test_reset_in_wait();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: %0d writes never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
